pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 107 ++++++++++
 tb/tb_pc_stack.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack for call/ret.
// Overflow and underflow are reported through sticky flags cleared by clr_err.
module pc_stack #(
    parameter int                ADDR_W    = 15,
    parameter int                DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           inc,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           clr_err,
    input  logic [ADDR_W-1:0]              in,
    output logic [ADDR_W-1:0]              out,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic [ADDR_W-1:0]              top,
    output logic                           full,
    output logic                           empty,
    output logic                           ovf_err,
    output logic                           unf_err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [ADDR_W-1:0] out_q, out_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic              push;
    logic [ADDR_W-1:0] push_val;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [ADDR_W-1:0] top_entry;
    logic              is_full;
    logic              is_empty;

    assign is_full   = (depth_q == DW'(DEPTH));
    assign is_empty  = (depth_q == '0);
    assign wr_idx    = IW'(depth_q);
    assign rd_idx    = IW'(depth_q - DW'(1));
    assign top_entry = stack_q[rd_idx];
    assign push_val  = out_q + ADDR_W'(1);

    // Only one command wins per cycle; a rejected call/ret still blocks lower commands.
    always_comb begin
        out_d   = out_q;
        depth_d = depth_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        push    = 1'b0;
        if (call) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                push    = 1'b1;
                depth_d = depth_q + DW'(1);
                out_d   = in;
            end
        end else if (ret) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
                out_d   = top_entry;
            end
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d = out_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage is never reset; depth alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[wr_idx] <= push_val;
        end
    end

    assign out     = out_q;
    assign depth   = depth_q;
    assign top     = is_empty ? '0 : top_entry;
    assign full    = is_full;
    assign empty   = is_empty;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack: directed scenarios followed by randomized commands,
// all compared against a queue-based return-stack model.
module tb_pc_stack;

    localparam int AW = 15;
    localparam int DP = 8;
    localparam int DW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0, clr_err = 1'b0;
    logic [AW-1:0] in = '0;
    logic [AW-1:0] out;
    logic [DW-1:0] depth;
    logic [AW-1:0] top;
    logic          full, empty, ovf_err, unf_err;

    int checks = 0;
    int errors = 0;

    // Reference model: a program counter plus a queue of return addresses.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stack [$];
    bit            m_ovf, m_unf;

    pc_stack #(.ADDR_W(AW), .DEPTH(DP), .RESET_VEC('0)) dut (
        .clk(clk), .rst(rst), .load(load), .inc(inc), .call(call), .ret(ret),
        .clr_err(clr_err), .in(in), .out(out), .depth(depth), .top(top),
        .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(bit l, bit i, bit c, bit r, bit clr, logic [AW-1:0] tgt);
        bit ov_ev = 1'b0;
        bit un_ev = 1'b0;
        if (c) begin
            if (m_stack.size() == DP) ov_ev = 1'b1;
            else begin
                m_stack.push_back(m_pc + AW'(1));
                m_pc = tgt;
            end
        end else if (r) begin
            if (m_stack.size() == 0) un_ev = 1'b1;
            else m_pc = m_stack.pop_back();
        end else if (l) begin
            m_pc = tgt;
        end else if (i) begin
            m_pc = m_pc + AW'(1);
        end
        m_ovf = ov_ev | (m_ovf & !clr);
        m_unf = un_ev | (m_unf & !clr);
    endtask

    task automatic check_one(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        logic [AW-1:0] exp_top;
        exp_top = (m_stack.size() == 0) ? '0 : m_stack[m_stack.size() - 1];
        check_one({tag, ".out"},   32'(out),     32'(m_pc));
        check_one({tag, ".depth"}, 32'(depth),   32'(m_stack.size()));
        check_one({tag, ".top"},   32'(top),     32'(exp_top));
        check_one({tag, ".full"},  32'(full),    32'(m_stack.size() == DP));
        check_one({tag, ".empty"}, 32'(empty),   32'(m_stack.size() == 0));
        check_one({tag, ".ovf"},   32'(ovf_err), 32'(m_ovf));
        check_one({tag, ".unf"},   32'(unf_err), 32'(m_unf));
    endtask

    // Drive one command for one clock edge, then advance the model to match.
    task automatic applyStimulus(bit l, bit i, bit c, bit r, bit clr, logic [AW-1:0] tgt);
        load = l; inc = i; call = c; ret = r; clr_err = clr; in = tgt;
        @(posedge clk);
        #1;
        model_step(l, i, c, r, clr, tgt);
        load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(string tag);
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        checkOutput("por");
        #5;
        rst = 1'b0;

        repeat (3) applyStimulus(0, 1, 0, 0, 0, '0);
        checkOutput("inc3");
        check_one("inc3.const", 32'(out), 32'h3);

        applyStimulus(1, 0, 0, 0, 0, 15'h0010);
        applyStimulus(0, 0, 1, 0, 0, 15'h0200);
        checkOutput("call1");
        check_one("call1.top_const", 32'(top), 32'h0011);
        applyStimulus(0, 0, 0, 1, 0, '0);
        checkOutput("ret1");
        check_one("ret1.out_const", 32'(out), 32'h0011);

        pulse_reset("rst_a");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(0, 0, 1, 0, 0, AW'(16'h0100 + k));
            checkOutput($sformatf("call_fill%0d", k));
        end
        check_one("ovf.out_eighth", 32'(out), 32'h0107);
        applyStimulus(0, 0, 0, 0, 1, '0);
        checkOutput("ovf_clr");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, 1, 0, '0);
            checkOutput($sformatf("unwind%0d", k));
        end

        pulse_reset("rst_b");
        applyStimulus(1, 0, 0, 0, 0, 15'h0005);
        applyStimulus(0, 0, 0, 1, 0, '0);
        checkOutput("unf");
        applyStimulus(0, 0, 0, 1, 1, '0);
        checkOutput("unf_clr_same");
        check_one("unf_clr_same.const", 32'(unf_err), 32'h1);
        applyStimulus(0, 0, 0, 0, 1, '0);
        checkOutput("unf_clr");

        applyStimulus(1, 0, 0, 0, 0, 15'h7FFF);
        applyStimulus(0, 1, 0, 0, 0, '0);
        checkOutput("wrap_inc");
        applyStimulus(1, 0, 0, 0, 0, 15'h7FFF);
        applyStimulus(0, 0, 1, 0, 0, 15'h0001);
        checkOutput("wrap_call");
        check_one("wrap_call.top_const", 32'(top), 32'h0);

        pulse_reset("rst_c");
        applyStimulus(1, 0, 0, 0, 0, 15'h0020);
        applyStimulus(1, 1, 1, 1, 0, 15'h0100);
        checkOutput("all_cmds");
        check_one("all_cmds.top_const", 32'(top), 32'h0021);
        #2;
        pulse_reset("rst_mid");

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 7) == 0), AW'($urandom));
            checkOutput($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
